// File: rtl/ex_stage_core.sv
// RV32I decode, execute and EX/MEM pipeline register.
// Decodes instr_i, forms the ALU result or branch/jump target, resolves the
// branch decision and registers everything the MEM/WB stages consume.
module ex_stage_core (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [31:0] alu_data_o,
    output logic        br_sel_o,
    output logic [31:0] pc_four_o,
    output logic [31:0] st_data_o,
    output logic [3:0]  ld_op_o,
    output logic        mem_wren_o,
    output logic        is_load_o,
    output logic        jump_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wren_o
);

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    // ALU op encoding is {alternate bit, funct3} so OP/OP-IMM map directly
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign rd         = instr_i[11:7];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

    logic            legal;
    logic            sel_pc_a;
    logic            sel_rs2_b;
    logic            is_lui;
    logic            is_jalr;
    logic            is_branch;
    logic            is_load;
    logic            is_store;
    logic            is_jump;
    logic            wr_rd;
    logic            alt_op;
    logic [3:0]      ld_op;
    logic [XLEN-1:0] imm;
    alu_op_e         alu_op;

    // Instruction decode: operand muxing, immediate choice and control fields
    always_comb begin
        legal     = 1'b0;
        sel_pc_a  = 1'b0;
        sel_rs2_b = 1'b0;
        is_lui    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_jump   = 1'b0;
        wr_rd     = 1'b0;
        alt_op    = 1'b0;
        ld_op     = 4'b0000;
        imm       = imm_i;
        alu_op    = ALU_ADD;
        unique case (opcode)
            OPC_LUI: begin
                legal  = 1'b1;
                imm    = imm_u;
                is_lui = 1'b1;
                wr_rd  = 1'b1;
            end
            OPC_AUIPC: begin
                legal    = 1'b1;
                sel_pc_a = 1'b1;
                imm      = imm_u;
                wr_rd    = 1'b1;
            end
            OPC_JAL: begin
                legal    = 1'b1;
                sel_pc_a = 1'b1;
                imm      = imm_j;
                is_jump  = 1'b1;
                wr_rd    = 1'b1;
            end
            OPC_JALR: begin
                legal   = 1'b1;
                is_jalr = 1'b1;
                is_jump = 1'b1;
                wr_rd   = 1'b1;
            end
            OPC_BRANCH: begin
                legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
                sel_pc_a  = 1'b1;
                imm       = imm_b;
                is_branch = 1'b1;
            end
            OPC_LOAD: begin
                is_load = 1'b1;
                wr_rd   = 1'b1;
                case (funct3)
                    3'b000:  begin legal = 1'b1; ld_op = 4'b1001; end
                    3'b001:  begin legal = 1'b1; ld_op = 4'b1011; end
                    3'b010:  begin legal = 1'b1; ld_op = 4'b1111; end
                    3'b100:  begin legal = 1'b1; ld_op = 4'b0001; end
                    3'b101:  begin legal = 1'b1; ld_op = 4'b0011; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                imm      = imm_s;
                is_store = 1'b1;
                case (funct3)
                    3'b000:  begin legal = 1'b1; ld_op = 4'b0001; end
                    3'b001:  begin legal = 1'b1; ld_op = 4'b0011; end
                    3'b010:  begin legal = 1'b1; ld_op = 4'b0111; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_IMM: begin
                legal  = 1'b1;
                wr_rd  = 1'b1;
                // Only SRAI uses instr[30]; for ADDI it is an immediate bit
                alt_op = (funct3 == 3'b101) && instr_i[30];
                alu_op = alu_op_e'({alt_op, funct3});
            end
            OPC_REG: begin
                legal     = 1'b1;
                sel_rs2_b = 1'b1;
                wr_rd     = 1'b1;
                alt_op    = ((funct3 == 3'b000) || (funct3 == 3'b101)) && instr_i[30];
                alu_op    = alu_op_e'({alt_op, funct3});
            end
            default: legal = 1'b0;
        endcase
    end

    logic [XLEN-1:0] op_a, op_b, alu_res;
    logic [4:0]      shamt;

    assign op_a  = sel_pc_a ? pc_i : rs1_data_i;
    assign op_b  = sel_rs2_b ? rs2_data_i : imm;
    assign shamt = op_b[4:0];

    // 32-bit ALU with wrap-around arithmetic
    always_comb begin
        alu_res = op_a + op_b;
        unique case (alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {31'b0, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = op_a + op_b;
        endcase
    end

    logic br_eq, br_lt, br_ltu, br_taken;

    assign br_eq  = rs1_data_i == rs2_data_i;
    assign br_lt  = $signed(rs1_data_i) < $signed(rs2_data_i);
    assign br_ltu = rs1_data_i < rs2_data_i;

    // Branch condition from the raw register operands
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] alu_data_d, pc_four_d, st_data_d;
    logic [3:0]      ld_op_d;
    logic            br_sel_d, mem_wren_d, is_load_d, jump_d, rd_wren_d;
    logic [4:0]      rd_addr_d;

    // Next-state values for the pipeline register; illegal decodes become NOPs
    always_comb begin
        alu_data_d = '0;
        if (legal) begin
            if (is_lui) begin
                alu_data_d = imm;
            end else if (is_jalr) begin
                alu_data_d = {alu_res[XLEN-1:1], 1'b0};
            end else begin
                alu_data_d = alu_res;
            end
        end
        br_sel_d   = legal && (is_jump || (is_branch && br_taken));
        ld_op_d    = legal ? ld_op : 4'b0000;
        mem_wren_d = legal && is_store;
        is_load_d  = legal && is_load;
        jump_d     = legal && is_jump;
        rd_wren_d  = legal && wr_rd && (rd != 5'd0);
        rd_addr_d  = rd;
        pc_four_d  = pc_i + XLEN'(4);
        st_data_d  = rs2_data_i;
    end

    logic [XLEN-1:0] alu_data_q, pc_four_q, st_data_q;
    logic [3:0]      ld_op_q;
    logic            br_sel_q, mem_wren_q, is_load_q, jump_q, rd_wren_q;
    logic [4:0]      rd_addr_q;

    // EX/MEM register: reset and flush clear, enable captures, otherwise hold
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            alu_data_q <= '0;
            br_sel_q   <= 1'b0;
            pc_four_q  <= '0;
            st_data_q  <= '0;
            ld_op_q    <= '0;
            mem_wren_q <= 1'b0;
            is_load_q  <= 1'b0;
            jump_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_wren_q  <= 1'b0;
        end else if (enable_i) begin
            alu_data_q <= alu_data_d;
            br_sel_q   <= br_sel_d;
            pc_four_q  <= pc_four_d;
            st_data_q  <= st_data_d;
            ld_op_q    <= ld_op_d;
            mem_wren_q <= mem_wren_d;
            is_load_q  <= is_load_d;
            jump_q     <= jump_d;
            rd_addr_q  <= rd_addr_d;
            rd_wren_q  <= rd_wren_d;
        end
    end

    assign alu_data_o = alu_data_q;
    assign br_sel_o   = br_sel_q;
    assign pc_four_o  = pc_four_q;
    assign st_data_o  = st_data_q;
    assign ld_op_o    = ld_op_q;
    assign mem_wren_o = mem_wren_q;
    assign is_load_o  = is_load_q;
    assign jump_o     = jump_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_wren_o  = rd_wren_q;

endmodule

// File: tb/tb_ex_stage_core.sv
// Bench for ex_stage_core: directed and random instructions, expected
// register contents queued by the driver and checked by a monitor.
module tb_ex_stage_core;

    logic        clk = 1'b0;
    logic        rst_n, enable, flush;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] alu_data, pc_four, st_data;
    logic [3:0]  ld_op;
    logic        br_sel, mem_wren, is_load, jump, rd_wren;

    ex_stage_core dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .enable_i   (enable),
        .flush_i    (flush),
        .instr_i    (instr),
        .pc_i       (pc),
        .rs1_data_i (rs1_data),
        .rs2_data_i (rs2_data),
        .rs1_addr_o (rs1_addr),
        .rs2_addr_o (rs2_addr),
        .alu_data_o (alu_data),
        .br_sel_o   (br_sel),
        .pc_four_o  (pc_four),
        .st_data_o  (st_data),
        .ld_op_o    (ld_op),
        .mem_wren_o (mem_wren),
        .is_load_o  (is_load),
        .jump_o     (jump),
        .rd_addr_o  (rd_addr),
        .rd_wren_o  (rd_wren)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic        br;
        logic [31:0] pc4;
        logic [31:0] st;
        logic [3:0]  ld;
        logic        mw;
        logic        isld;
        logic        jmp;
        logic [4:0]  rd;
        logic        rdw;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {im, r1, f3, d, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2, r1,
                                          input logic [2:0] f3);
        return {im[11:5], r2, r1, f3, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2, r1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    // Plain arithmetic for the OP / OP-IMM families
    function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, y);
        int sx, sy;
        sx = x;
        sy = y;
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return (sx < sy) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'(sx >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    // Reference: what the stage should register for one instruction
    function automatic exp_t model(input logic [31:0] ins, p, a, b);
        exp_t e;
        logic [2:0]  f3;
        logic [31:0] ii, is, ib, iu, ij;
        int          sa, sb;
        bit          tk;
        f3 = ins[14:12];
        sa = a;
        sb = b;
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'h000};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e     = '0;
        e.pc4 = p + 32'd4;
        e.st  = b;
        e.rd  = ins[11:7];
        case (ins[6:0])
            7'h37: begin e.alu = iu; e.rdw = 1; end
            7'h17: begin e.alu = p + iu; e.rdw = 1; end
            7'h6F: begin e.alu = p + ij; e.br = 1; e.jmp = 1; e.rdw = 1; end
            7'h67: begin e.alu = (a + ii) & ~32'd1; e.br = 1; e.jmp = 1; e.rdw = 1; end
            7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (sa < sb);
                    3'd5: tk = !(sa < sb);
                    3'd6: tk = (a < b);
                    default: tk = !(a < b);
                endcase
                e.alu = p + ib;
                e.br  = tk;
            end
            7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                e.alu  = a + ii;
                e.isld = 1;
                e.rdw  = 1;
                e.ld   = (f3 == 3'd0) ? 4'b1001 : (f3 == 3'd1) ? 4'b1011 :
                         (f3 == 3'd2) ? 4'b1111 : (f3 == 3'd4) ? 4'b0001 : 4'b0011;
            end
            7'h23: if (f3 <= 3'd2) begin
                e.alu = a + is;
                e.mw  = 1;
                e.ld  = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b0111;
            end
            7'h13: begin e.alu = arith(f3, (f3 == 3'd5) && ins[30], a, ii); e.rdw = 1; end
            7'h33: begin
                e.alu = arith(f3, (f3 == 3'd0 || f3 == 3'd5) && ins[30], a, b);
                e.rdw = 1;
            end
            default: ;
        endcase
        if (e.rd == 5'd0) e.rdw = 0;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the register should hold after the edge
    task automatic drive(input logic r, f, en, input logic [31:0] ins, p, a, b);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        flush    = f;
        enable   = en;
        instr    = ins;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
        if (!r || f)  e = '0;
        else if (en)  e = model(ins, p, a, b);
        else          e = last_exp;
        last_exp = e;
        exp_q.push_back(e);
        #1;
        checks++;
        if (rs1_addr !== ins[19:15] || rs2_addr !== ins[24:20]) begin
            errors++;
            $display("FAIL raddr: got %0d/%0d want %0d/%0d", rs1_addr, rs2_addr,
                     ins[19:15], ins[24:20]);
        end
    endtask

    task automatic run(input logic [31:0] ins, p, a, b);
        drive(1'b1, 1'b0, 1'b1, ins, p, a, b);
    endtask

    // Monitor: after every edge compare the register contents with the queued expectation
    initial begin
        exp_t got, want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{alu: alu_data, br: br_sel, pc4: pc_four, st: st_data, ld: ld_op,
                         mw: mem_wren, isld: is_load, jmp: jump, rd: rd_addr, rdw: rd_wren};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL stage t=%0t: got alu=%h br=%b pc4=%h st=%h ld=%b mw=%b ld=%b j=%b rd=%0d w=%b | want alu=%h br=%b pc4=%h st=%h ld=%b mw=%b ld=%b j=%b rd=%0d w=%b",
                             $time, got.alu, got.br, got.pc4, got.st, got.ld, got.mw, got.isld,
                             got.jmp, got.rd, got.rdw, want.alu, want.br, want.pc4, want.st,
                             want.ld, want.mw, want.isld, want.jmp, want.rd, want.rdw);
                end
            end
        end
    end

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops[10];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
        // keep funct7 to the two legal patterns for OP most of the time
        if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0) w[31:25] = {1'b0, w[30], 5'b0};
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; enable = 1'b0;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        last_exp = '0;

        // reset wins over a valid ADD, then the ADD appears
        drive(1'b0, 1'b0, 1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h10, 32'h7FFF_FFFF, 32'd1);
        run(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h10, 32'h7FFF_FFFF, 32'd1);
        // R-type arithmetic corners
        run(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'h14, 32'd0, 32'd1);
        run(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd6), 32'h18, 32'h8000_0000, 32'd4);
        run(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd7), 32'h1C, 32'd1, 32'hFFFF_FFFF);
        run(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd7), 32'h1C, 32'd1, 32'hFFFF_FFFF);
        // loads and stores
        run(enc_i(12'd8, 5'd1, 3'd2, 5'd5, 7'h03), 32'h20, 32'h100, 32'h0);
        run(enc_i(12'd3, 5'd1, 3'd4, 5'd5, 7'h03), 32'h24, 32'h100, 32'h0);
        run(enc_s(12'hFFC, 5'd2, 5'd1, 3'd1), 32'h28, 32'h200, 32'hABCD);
        // branches
        run(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h40, 32'd5, 32'd5);
        run(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1), 32'h40, 32'd5, 32'd5);
        run(enc_b(13'h0010, 5'd2, 5'd1, 3'd4), 32'h44, 32'hFFFF_FFFF, 32'd1);
        run(enc_b(13'h0010, 5'd2, 5'd1, 3'd6), 32'h48, 32'hFFFF_FFFF, 32'd1);
        // jumps
        run(enc_j(21'd16, 5'd1), 32'h20, 32'h0, 32'h0);
        run(enc_i(12'd0, 5'd1, 3'd0, 5'd1, 7'h67), 32'h50, 32'h101, 32'h0);
        run(enc_j(21'd16, 5'd0), 32'h60, 32'h0, 32'h0);
        // hold while inputs keep changing
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 1'b0, rand_instr(), $urandom, $urandom, $urandom);
        // flush, illegal opcode, LUI, reset+flush together
        drive(1'b1, 1'b1, 1'b1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h70, 32'd1, 32'd2);
        run(32'h0000_007F, 32'h74, 32'h1234, 32'h5678);
        run({20'h12345, 5'd9, 7'h37}, 32'h78, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, {20'h12345, 5'd9, 7'h37}, 32'h7C, 32'h0, 32'h0);

        // random traffic with occasional stalls, flushes and resets
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 19);
            drive((k != 0), (k == 1), (k > 3), rand_instr(), $urandom & 32'hFFFF_FFFC,
                  rand_operand(), rand_operand());
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_core.md
Name: ex_stage_core

Overview:
- RV32I decode + execute + EX/MEM pipeline register in one block.
- Takes the fetched instruction with its PC and the register-file operands, decodes it, computes the ALU result and the branch/jump decision, and registers everything the MEM/WB stages need.
- Sits between the regfile read and the LSU. It replaces the separate decoder, alu and ex_mem blocks.

Parameters:
- none (XLEN fixed at 32)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, active-low, synchronous
- enable_i  in  1  1 = register captures; 0 = register holds
- flush_i  in  1  1 = capture a bubble (all control fields 0)
- instr_i  in  32  instruction word
- pc_i  in  32  PC of instr_i
- rs1_data_i  in  32  regfile read data for rs1
- rs2_data_i  in  32  regfile read data for rs2
- rs1_addr_o  out  5  combinational, instr_i[19:15]
- rs2_addr_o  out  5  combinational, instr_i[24:20]
- alu_data_o  out  32  registered ALU result / branch target / memory address
- br_sel_o  out  1  registered; 1 = next PC is alu_data_o
- pc_four_o  out  32  registered pc_i+4
- st_data_o  out  32  registered rs2_data_i
- ld_op_o  out  4  registered; [3]=signed, [2:0]=111 word, 011 half, 001 byte
- mem_wren_o  out  1  registered; store
- is_load_o  out  1  registered; load
- jump_o  out  1  registered; JAL/JALR (writeback selects pc_four)
- rd_addr_o  out  5  registered instr_i[11:7]
- rd_wren_o  out  1  registered regfile write enable

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-low, sampled on the clk_i rising edge.
  - Capture priority at each rising edge: rst_ni=0 > flush_i=1 > enable_i=1 > hold.
  - Reset and flush set all registered outputs to 0.
- Latency: combinational from the inputs; outputs valid one cycle after capture. rs1/rs2_addr_o are purely combinational.
- Immediates:
  - I, S, B, U and J types per the RV32I spec, sign-extended.
  - Shift-immediate forms use shamt = instr[24:20].
- Operand selection:
  - op_a = pc_i for AUIPC, JAL and branches; otherwise rs1_data_i.
  - op_b = imm for everything except R-type; R-type uses rs2_data_i.
- ALU operations, 32-bit wrap-around:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Shifts use op_b[4:0].
  - SLT/SLTU produce 1 or 0.
  - SRA is arithmetic.
  - SUB is selected for R-type when funct7[5]=1. SRA/SRAI are selected when funct7[5]=1.
- Per-opcode results:
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - Loads/stores: result = rs1+imm (address).
  - JAL: result = pc+imm.
  - JALR: result = (rs1+imm) with bit0 cleared.
  - Branches: result = pc+imm (target).
- Branch compare:
  - Uses rs1_data_i vs rs2_data_i, never the operand muxes.
  - BEQ/BNE: equality. BLT/BGE: signed. BLTU/BGEU: unsigned.
  - br_sel = 1 for a taken branch, JAL or JALR; else 0.
- Control fields:
  - Loads: is_load=1, rd_wren=1.
  - Stores: mem_wren=1, rd_wren=0.
  - Branches: rd_wren=0.
  - JAL/JALR: jump=1, rd_wren=1.
  - OP, OP-IMM, LUI, AUIPC: rd_wren=1.
- ld_op encoding:
  - lb=1001, lh=1011, lw=1111, lbu=0001, lhu=0011.
  - sb=0001, sh=0011, sw=0111.
  - All other instructions: 0000.
- rd_wren is forced to 0 when rd=0.
- Illegal or unsupported opcodes (including FENCE/SYSTEM) decode as NOP: all control 0, br_sel=0, alu_data=0.
- Illegal funct3 for load/store/branch is also a NOP.
- Hold (enable_i=0, flush_i=0, rst_ni=1): every registered output keeps its value. The combinational address outputs still follow instr_i.
- Flush and reset assert simultaneously: reset wins (the result is identical, all 0).

Test Plan:
- Reset: rst_ni=0 for 1 edge with a valid ADD input -> all registered outputs 0. rst_ni=1 next edge -> result appears.
- R-type arithmetic:
  - ADD x3,x1,x2 with rs1=0x7FFFFFFF, rs2=1 -> alu_data=0x80000000, rd_addr=3, rd_wren=1.
  - SUB with rs1=0, rs2=1 -> 0xFFFFFFFF.
  - SRA of 0x80000000 by 4 -> 0xF8000000.
  - SLTU with rs1=1, rs2=0xFFFFFFFF -> 1.
  - SLT on the same operands -> 0.
- Loads and stores:
  - LW x5,8(x1) with rs1=0x100 -> alu_data=0x108, is_load=1, ld_op=1111.
  - LBU -> ld_op=0001.
  - SH with rs2=0xABCD -> mem_wren=1, st_data=0xABCD, rd_wren=0, ld_op=0011.
- Branches:
  - BEQ equal, pc=0x40, imm=-8 -> br_sel=1, alu_data=0x38.
  - BNE equal -> br_sel=0.
  - BLT with -1 vs 1 -> taken.
  - BLTU with 0xFFFFFFFF vs 1 -> not taken.
- Jumps:
  - JAL x1,+16 at pc=0x20 -> br_sel=1, jump=1, alu_data=0x30, pc_four=0x24.
  - JALR with rs1=0x101, imm=0 -> alu_data=0x100.
  - JAL x0 -> rd_wren=0.
- Control corner cases:
  - enable_i=0 with changing inputs -> outputs hold.
  - flush_i=1 -> all outputs 0.
  - Illegal opcode 0x0000007F -> NOP.
  - LUI 0x12345 -> alu_data=0x12345000.
